// File: rtl/countdown_start_ctrl.sv
// Push-button start controller for the countdown counter.
// Synchronises, debounces and queues requests; tracks each run.
module countdown_start_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PENDING     = 3,
    parameter int TIMEOUT         = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             btn_i,
    input  logic                             ready_i,
    output logic                             start_o,
    output logic                             busy_o,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_o,
    output logic                             done_o,
    output logic                             dropped_o,
    output logic                             fault_o
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PMAX  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t next;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   deb;
    logic [DW-1:0]          cnt;
    logic                   flip;
    logic                   press;
    logic [PW-1:0]          pending;
    logic [TW-1:0]          tcnt;
    logic                   issue;
    logic                   timeout;
    logic                   finish;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // A new level is accepted on the edge that completes the hold window.
    assign flip  = (s != deb) && (cnt == DLAST);
    assign press = flip && s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (s == deb) begin
            cnt <= '0;
        end else if (flip) begin
            deb <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign issue   = (state == IDLE) && (pending != '0) && ready_i;
    assign timeout = (state == WAIT_BUSY) && ready_i && (tcnt == TLAST);
    assign finish  = (state == WAIT_DONE) && ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      if (issue) next = ISSUE;
            ISSUE:     next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!ready_i) begin
                    next = WAIT_DONE;
                end else if (tcnt == TLAST) begin
                    next = IDLE;
                end
            end
            WAIT_DONE: if (ready_i) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state != IDLE);
        pending_o = pending;
    end

    // A press landing on the issue edge takes the slot being freed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (press && !issue && (pending != PMAX)) begin
            pending <= pending + 1'b1;
        end else if (!press && issue) begin
            pending <= pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (state == ISSUE) begin
            tcnt <= '0;
        end else if ((state == WAIT_BUSY) && ready_i && (tcnt != TLAST)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_o   <= 1'b0;
            done_o    <= 1'b0;
            dropped_o <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            start_o   <= issue;
            done_o    <= finish;
            dropped_o <= press && !issue && (pending == PMAX);
            fault_o   <= fault_o | timeout;
        end
    end

endmodule

// File: tb/tb_countdown_start_ctrl.sv
// Bench for countdown_start_ctrl: vector rows with a scoreboard queue,
// plus a bench-side countdown counter that drives ready_i.
module tb_countdown_start_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_i;
    logic       ready_i;
    logic       start_o;
    logic       busy_o;
    logic [1:0] pending_o;
    logic       done_o;
    logic       dropped_o;
    logic       fault_o;

    logic       auto_rdy;
    logic       ready_force;
    logic [3:0] ctr = 4'd0;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_done = 0;
    int n_drop = 0;
    int b2b = 0;
    int max_bounce = 0;
    logic prev_start = 1'b0;
    logic cur_mon = 1'b0;

    typedef struct {
        logic rst;
        logic btn;
        logic auto_r;
        logic rdy;
        logic mon;
        int   n;
        int   pend;
        int   busy;
        int   fault;
        int   starts;
        int   dones;
        int   drops;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    countdown_start_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i),
        .ready_i   (ready_i),
        .start_o   (start_o),
        .busy_o    (busy_o),
        .pending_o (pending_o),
        .done_o    (done_o),
        .dropped_o (dropped_o),
        .fault_o   (fault_o)
    );

    always #5 clk = ~clk;

    // Counter model: loads 8 on start, ready while sitting at zero.
    always @(posedge clk) begin
        if (start_o === 1'b1) begin
            ctr <= 4'd8;
        end else if (ctr != 4'd0) begin
            ctr <= ctr - 4'd1;
        end
    end

    assign ready_i = auto_rdy ? (ctr == 4'd0) : ready_force;

    always @(posedge clk) begin
        #1;
        if (start_o === 1'b1) begin
            n_start++;
            if (prev_start === 1'b1) b2b++;
        end
        if (done_o === 1'b1) n_done++;
        if (dropped_o === 1'b1) n_drop++;
        prev_start = start_o;
        if (cur_mon && (int'(pending_o) > max_bounce)) begin
            max_bounce = int'(pending_o);
        end
    end

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d want %0d",
                     name, row, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic b,
                                input logic a, input logic rd,
                                input logic m, input int n,
                                input int p, input int bu,
                                input int f, input int s,
                                input int d, input int dr);
        vec_t v;
        v.rst = r;  v.btn = b;  v.auto_r = a; v.rdy = rd;
        v.mon = m;  v.n = n;    v.pend = p;   v.busy = bu;
        v.fault = f; v.starts = s; v.dones = d; v.drops = dr;
        tbl.push_back(v);
    endfunction

    initial begin
        int s0, d0, r0;
        vec_t e;

        rst_n = 1'b0;
        btn_i = 1'b0;
        auto_rdy = 1'b1;
        ready_force = 1'b0;

        // reset, then a single press run
        add(0,0,1,0,0, 3, 0,0,0, 0,0,0);
        add(1,1,1,0,0, 5, 0,0,0, 0,0,0);
        add(1,1,1,0,0, 1, 1,0,0, 0,0,0);
        add(1,1,1,0,0, 1, 0,1,0, 1,0,0);
        add(1,0,1,0,0,10, 0,0,0, 0,1,0);
        add(1,0,1,0,0, 3, 0,0,0, 0,0,0);
        // bounce, then settle high
        for (int i = 0; i < 10; i++) begin
            add(1,(i % 2 == 0),1,0,1, 2, 0,0,0, 0,0,0);
        end
        add(1,1,1,0,1,30, 0,0,0, 1,1,0);
        add(1,0,1,0,0,10, 0,0,0, 0,0,0);
        // saturation with ready held low
        for (int k = 1; k <= 5; k++) begin
            add(1,1,0,0,0, 8, (k > 3) ? 3 : k,0,0, 0,0,(k > 3));
            add(1,0,0,0,0, 8, (k > 3) ? 3 : k,0,0, 0,0,0);
        end
        add(1,0,1,0,0, 1, 2,1,0, 1,0,0);
        add(1,0,1,0,0,39, 0,0,0, 2,3,0);
        // press accepted on the issue edge
        add(1,1,0,0,0, 8, 1,0,0, 0,0,0);
        add(1,0,0,0,0, 8, 1,0,0, 0,0,0);
        add(1,1,0,0,0, 5, 1,0,0, 0,0,0);
        add(1,1,0,1,0, 1, 1,1,0, 1,0,0);
        add(1,0,1,0,0,40, 0,0,0, 1,2,0);
        // stuck counter
        add(1,1,0,1,0, 8, 0,1,0, 1,0,0);
        add(1,0,0,1,0, 8, 0,1,0, 0,0,0);
        add(1,1,0,1,0, 7, 1,1,0, 0,0,0);
        add(1,1,0,1,0, 1, 1,0,1, 0,0,0);
        add(1,0,1,0,0,40, 0,0,1, 1,1,0);
        // reset during WAIT_DONE with two queued
        for (int k = 1; k <= 3; k++) begin
            add(1,1,0,0,0, 8, k,0,1, 0,0,0);
            add(1,0,0,0,0, 8, k,0,1, 0,0,0);
        end
        add(1,0,1,0,0, 3, 2,1,1, 1,0,0);
        add(0,0,1,0,0, 1, 0,0,0, 0,0,0);
        add(0,0,1,0,0, 2, 0,0,0, 0,0,0);
        add(1,0,1,0,0,15, 0,0,0, 0,0,0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst;
            btn_i = tbl[i].btn;
            auto_rdy = tbl[i].auto_r;
            ready_force = tbl[i].rdy;
            cur_mon = tbl[i].mon;
            exp_q.push_back(tbl[i]);
            s0 = n_start;
            d0 = n_done;
            r0 = n_drop;
            repeat (tbl[i].n) @(posedge clk);
            #2;
            e = exp_q.pop_front();
            chk("pending", i, 32'(pending_o), e.pend);
            chk("busy", i, 32'(busy_o), e.busy);
            chk("fault", i, 32'(fault_o), e.fault);
            chk("starts", i, n_start - s0, e.starts);
            chk("dones", i, n_done - d0, e.dones);
            chk("drops", i, n_drop - r0, e.drops);
        end
        cur_mon = 1'b0;

        chk("bounce_max_pending", -1, max_bounce, 1);
        chk("start_back_to_back", -1, b2b, 0);
        chk("scoreboard_empty", -1, exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
